// File: rtl/wb_stage.sv
// wb_stage: writeback stage (ALU/link/load select, load wait with timeout; WB_MISALIGN_CHECK_EN adds misaligned-load errors)
module wb_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_pc,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic                  in_is_link,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic [DATA_WIDTH-1:0] in_alu,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  retire,
    output logic [31:0]           retire_pc,
    output logic                  wb_err
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;
    state_t state, state_nx;
    logic [7:0] cnt;
    logic [ADDR_WIDTH-1:0] ld_rd;
    logic ld_wen;
    logic [2:0] ld_f3;
    logic [1:0] ld_lo;
    logic [31:0] ld_pc;
    logic [DATA_WIDTH-1:0] sh_b, sh_h, ld_data, nl_data;
    logic [7:0] b;
    logic [15:0] h;
    logic accept, ld_done, timeout, misalign, wen_nl, wen_ld;
    assign in_ready   = state == IDLE && rst_n;
    assign mem_rready = state == WAIT_MEM;
    assign accept     = in_valid && in_ready;
    assign sh_b = mem_rdata >> {ld_lo, 3'b000};
    assign sh_h = mem_rdata >> {ld_lo[1], 4'b0000};
    assign b = sh_b[7:0];
    assign h = sh_h[15:0];
`ifdef WB_MISALIGN_CHECK_EN
    assign misalign = (ld_f3[1:0] == 2'b01 && ld_lo[0]) || (ld_f3 == 3'b010 && ld_lo != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    always_comb begin
        ld_data  = ld_f3 == 3'b000 ? {{(DATA_WIDTH-8){b[7]}}, b} :
                   ld_f3 == 3'b001 ? {{(DATA_WIDTH-16){h[15]}}, h} :
                   ld_f3 == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, b} :
                   ld_f3 == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, h} : mem_rdata;
        nl_data  = in_is_link ? in_pc + 32'd4 : in_alu;
        ld_done  = state == WAIT_MEM && mem_rvalid;
        timeout  = state == WAIT_MEM && !mem_rvalid && cnt == 8'(MEM_TIMEOUT - 1);
        wen_nl   = accept && !in_is_load && in_rd_wen && in_rd != '0;
        wen_ld   = ld_done && !misalign && ld_wen && ld_rd != '0;
        state_nx = accept && in_is_load ? WAIT_MEM : (ld_done || timeout) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ld_rd     <= '0;
            ld_wen    <= 1'b0;
            ld_f3     <= '0;
            ld_lo     <= '0;
            ld_pc     <= '0;
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            retire    <= 1'b0;
            retire_pc <= '0;
            wb_err    <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= state == WAIT_MEM ? cnt + 8'd1 : 8'd0;
            rf_wen <= wen_nl || wen_ld;
            retire <= (accept && !in_is_load) || ld_done || timeout;
            wb_err <= timeout || (ld_done && misalign);
            if (accept) begin
                ld_rd  <= in_rd;
                ld_wen <= in_rd_wen;
                ld_f3  <= in_funct3;
                ld_lo  <= in_addr_lo;
                ld_pc  <= in_pc;
            end
            if (wen_nl) begin
                rf_waddr <= in_rd;
                rf_wdata <= nl_data;
            end else if (wen_ld) begin
                rf_waddr <= ld_rd;
                rf_wdata <= ld_data;
            end
            if (accept && !in_is_load) retire_pc <= in_pc;
            else if (ld_done || timeout) retire_pc <= ld_pc;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed table and load-sequence checks for wb_stage (MEM_TIMEOUT=4)
module tb_wb_stage;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_rd_wen = 1'b0, in_is_link = 1'b0, in_is_load = 1'b0;
    logic [31:0] in_pc = '0, in_alu = '0, mem_rdata = '0;
    logic [4:0] in_rd = '0;
    logic [2:0] in_funct3 = '0;
    logic [1:0] in_addr_lo = '0;
    logic mem_rvalid = 1'b0;
    logic in_ready, mem_rready, rf_wen, retire, wb_err;
    logic [4:0] rf_waddr;
    logic [31:0] rf_wdata, retire_pc;
    int checks = 0, errors = 0;
    typedef struct {
        logic v; logic [4:0] rd; logic wen; logic link; logic [31:0] pc; logic [31:0] alu;
        logic e_wen; logic [4:0] e_waddr; logic [31:0] e_wdata; logic e_ret; logic [31:0] e_rpc;
    } vec_t;
    vec_t tbl [8];
    always #5 clk = ~clk;
    wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_is_link(in_is_link), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu(in_alu),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire(retire), .retire_pc(retire_pc), .wb_err(wb_err)
    );
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic run_load(input string nm, input logic [2:0] f3, input logic [1:0] lo,
                            input logic [4:0] rd, input logic [31:0] pc, input int nwait,
                            input logic give, input logic [31:0] rdata, input logic e_wen,
                            input logic [31:0] e_wdata, input logic e_err);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd_wen = 1'b1; in_is_link = 1'b0;
        in_funct3 = f3; in_addr_lo = lo; in_rd = rd; in_pc = pc; in_alu = 32'hDEAD_BEEF;
        step;
        in_valid = 1'b0; in_is_load = 1'b0;
        chk({nm, " in_ready wait"}, in_ready, 0);
        chk({nm, " mem_rready wait"}, mem_rready, 1);
        for (int i = 0; i < nwait; i++) begin
            step;
            chk({nm, " retire wait"}, retire, 0);
            chk({nm, " rf_wen wait"}, rf_wen, 0);
        end
        mem_rvalid = give; mem_rdata = rdata;
        step;
        mem_rvalid = 1'b0;
        chk({nm, " rf_wen"}, rf_wen, e_wen);
        if (e_wen) begin
            chk({nm, " waddr"}, rf_waddr, rd);
            chk({nm, " wdata"}, rf_wdata, e_wdata);
        end
        chk({nm, " retire"}, retire, 1);
        chk({nm, " retire_pc"}, retire_pc, pc);
        chk({nm, " wb_err"}, wb_err, e_err);
        chk({nm, " in_ready done"}, in_ready, 1);
        step;
        chk({nm, " retire pulse"}, retire, 0);
        chk({nm, " wb_err pulse"}, wb_err, 0);
    endtask
    initial begin
        tbl[0] = '{1, 5'd5, 1, 0, 32'h100,        32'h1234,     1, 5'd5, 32'h1234,     1, 32'h100};
        tbl[1] = '{1, 5'd1, 1, 1, 32'hFFFF_FFFC, 32'hDEAD,     1, 5'd1, 32'h0,        1, 32'hFFFF_FFFC};
        tbl[2] = '{1, 5'd0, 1, 0, 32'h108,        32'h5555,     0, 5'd1, 32'h0,        1, 32'h108};
        tbl[3] = '{1, 5'd7, 1, 0, 32'h10C,        32'h77,       1, 5'd7, 32'h77,       1, 32'h10C};
        tbl[4] = '{0, 5'd9, 1, 0, 32'h110,        32'h99,       0, 5'd7, 32'h77,       0, 32'h10C};
        tbl[5] = '{1, 5'd9, 0, 0, 32'h110,        32'h99,       0, 5'd7, 32'h77,       1, 32'h110};
        tbl[6] = '{1, 5'd3, 1, 1, 32'h200,        32'h1,        1, 5'd3, 32'h204,      1, 32'h200};
        tbl[7] = '{1, 5'd4, 1, 0, 32'h300,        32'hABCD,     1, 5'd4, 32'hABCD,     1, 32'h300};
        step;
        step;
        chk("reset rf_wen", rf_wen, 0);
        chk("reset retire", retire, 0);
        chk("reset wb_err", wb_err, 0);
        chk("reset waddr", rf_waddr, 0);
        chk("reset wdata", rf_wdata, 0);
        chk("reset retire_pc", retire_pc, 0);
        chk("reset in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("idle in_ready", in_ready, 1);
        chk("idle mem_rready", mem_rready, 0);
        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].v; in_rd = tbl[i].rd; in_rd_wen = tbl[i].wen;
            in_is_link = tbl[i].link; in_pc = tbl[i].pc; in_alu = tbl[i].alu;
            step;
            chk($sformatf("vec%0d rf_wen", i), rf_wen, tbl[i].e_wen);
            chk($sformatf("vec%0d waddr", i), rf_waddr, tbl[i].e_waddr);
            chk($sformatf("vec%0d wdata", i), rf_wdata, tbl[i].e_wdata);
            chk($sformatf("vec%0d retire", i), retire, tbl[i].e_ret);
            chk($sformatf("vec%0d retire_pc", i), retire_pc, tbl[i].e_rpc);
            chk($sformatf("vec%0d wb_err", i), wb_err, 0);
        end
        in_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        step;
        mem_rvalid = 1'b0;
        chk("idle rvalid rf_wen", rf_wen, 0);
        chk("idle rvalid retire", retire, 0);
        chk("idle rvalid mem_rready", mem_rready, 0);
        run_load("lb3",  3'b000, 2'd3, 5'd10, 32'h400, 2, 1, 32'h80AA_BBCC, 1, 32'hFFFF_FF80, 0);
        run_load("lhu2", 3'b101, 2'd2, 5'd11, 32'h404, 0, 1, 32'h80AA_BBCC, 1, 32'h0000_80AA, 0);
        run_load("lbu1", 3'b100, 2'd1, 5'd12, 32'h408, 1, 1, 32'h80AA_BBCC, 1, 32'h0000_00BB, 0);
        run_load("lh0",  3'b001, 2'd0, 5'd13, 32'h40C, 1, 1, 32'h1234_F00D, 1, 32'hFFFF_F00D, 0);
        run_load("lw0x0", 3'b010, 2'd0, 5'd0, 32'h410, 0, 1, 32'h5A5A_5A5A, 0, 32'h0, 0);
        run_load("tmo",  3'b010, 2'd0, 5'd14, 32'h414, 3, 0, 32'h0, 0, 32'h0, 1);
        run_load("edge", 3'b010, 2'd0, 5'd15, 32'h418, 3, 1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 0);
`ifdef WB_MISALIGN_CHECK_EN
        run_load("lw2",  3'b010, 2'd2, 5'd16, 32'h41C, 1, 1, 32'h1234_5678, 0, 32'h0, 1);
`else
        run_load("lw2",  3'b010, 2'd2, 5'd16, 32'h41C, 1, 1, 32'h1234_5678, 1, 32'h1234_5678, 0);
`endif
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd17; in_rd_wen = 1'b1; in_funct3 = 3'b010;
        in_addr_lo = 2'd0; in_pc = 32'h500;
        step;
        in_valid = 1'b0; in_is_load = 1'b0;
        step;
        rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        step;
        chk("rst wait rf_wen", rf_wen, 0);
        chk("rst wait retire", retire, 0);
        chk("rst wait wdata", rf_wdata, 0);
        rst_n = 1'b1;
        step;
        mem_rvalid = 1'b0;
        chk("post rst rf_wen", rf_wen, 0);
        chk("post rst retire", retire, 0);
        chk("post rst in_ready", in_ready, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
